// File: rtl/tlc_pkg.sv
// rtl/tlc_pkg.sv - state encodings, timer field layout and dwell lookup for traffic_light_ctrl
package tlc_pkg;

  typedef enum logic [1:0] {
    ST_RED    = 2'b00,
    ST_GREEN  = 2'b01,
    ST_YELLOW = 2'b10,
    ST_BLINK  = 2'b11
  } tlc_state_e;

  localparam int CNT_W   = 12;

  localparam int G2Y_LSB = 20;
  localparam int G2Y_W   = 12;
  localparam int R2G_LSB = 8;
  localparam int R2G_W   = 12;
  localparam int Y2R_LSB = 0;
  localparam int Y2R_W   = 8;

  // Dwell of the state being entered, taken from the field that ends it.
  function automatic logic [CNT_W-1:0] dwell_of(tlc_state_e st, logic [31:0] timer);
    logic [CNT_W-1:0] v;
    case (st)
      ST_GREEN:  v = timer[G2Y_LSB +: G2Y_W];
      ST_YELLOW: v = CNT_W'(timer[Y2R_LSB +: Y2R_W]);
      default:   v = timer[R2G_LSB +: R2G_W];
    endcase
    return v;
  endfunction

endpackage

// File: rtl/tlc_tick_gen.sv
// rtl/tlc_tick_gen.sv - prescaler emitting a one-cycle tick every TICK_DIV pclk cycles
module tlc_tick_gen #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic pclk,
  input  logic presetn,
  input  logic clr_i,
  output logic tick_o
);

  // With TICK_DIV=1 the counter never leaves zero, so tick stays high.
  localparam logic [15:0] LAST = 16'(TICK_DIV - 1);

  logic [15:0] cnt_q;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      cnt_q <= '0;
    end else if (clr_i || cnt_q == LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/traffic_light_ctrl.sv
// rtl/traffic_light_ctrl.sv - red/green/yellow sequencer with dwell timers and lamp blink mode
module traffic_light_ctrl
  import tlc_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 1,
  parameter int unsigned BLINK_HALF = 4
) (
  input  logic        pclk,
  input  logic        presetn,
  input  logic        mod_en,
  input  logic        blink_yellow,
  input  logic        blink_red,
  input  logic        profile,
  input  logic [31:0] timer_0,
  input  logic [31:0] timer_1,
  output logic [1:0]  state,
  output logic        lamp_red,
  output logic        lamp_yellow,
  output logic        lamp_green
);

  localparam logic [CNT_W-1:0] BLINK_LOAD = CNT_W'(BLINK_HALF);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  tlc_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] bcnt_q;
  logic             en_q;
  logic             blink_sel_q;
  logic             lamp_red_q;
  logic             lamp_yellow_q;
  logic             lamp_green_q;

  logic             tick;
  logic             blink_req;
  logic [31:0]      timer_sel;
  tlc_state_e       next_d;
  logic [CNT_W-1:0] next_load;
  logic [CNT_W-1:0] red_load;

  tlc_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .pclk   (pclk),
    .presetn(presetn),
    .clr_i  (!mod_en),
    .tick_o (tick)
  );

  assign blink_req = blink_red | blink_yellow;
  assign timer_sel = profile ? timer_1 : timer_0;

  always_comb begin
    next_d = ST_RED;
    case (state_q)
      ST_RED:   next_d = ST_GREEN;
      ST_GREEN: next_d = ST_YELLOW;
      default:  next_d = ST_RED;
    endcase
  end

  assign next_load = dwell_of(next_d, timer_sel);
  assign red_load  = dwell_of(ST_RED, timer_sel);

  // A loaded value of 0 expires on the first tick just like 1, via the <= 1 test.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q       <= ST_RED;
      cnt_q         <= '0;
      bcnt_q        <= '0;
      en_q          <= 1'b0;
      blink_sel_q   <= 1'b0;
      lamp_red_q    <= 1'b0;
      lamp_yellow_q <= 1'b0;
      lamp_green_q  <= 1'b0;
    end else begin
      en_q <= mod_en;
      if (!mod_en) begin
        state_q       <= ST_RED;
        lamp_red_q    <= 1'b0;
        lamp_yellow_q <= 1'b0;
        lamp_green_q  <= 1'b0;
      end else if (blink_req) begin
        if (state_q != ST_BLINK || blink_sel_q != blink_red) begin
          state_q       <= ST_BLINK;
          blink_sel_q   <= blink_red;
          bcnt_q        <= BLINK_LOAD;
          lamp_red_q    <= blink_red;
          lamp_yellow_q <= !blink_red;
          lamp_green_q  <= 1'b0;
        end else if (tick) begin
          if (bcnt_q <= CNT_ONE) begin
            bcnt_q        <= BLINK_LOAD;
            lamp_red_q    <= blink_sel_q ? !lamp_red_q : 1'b0;
            lamp_yellow_q <= blink_sel_q ? 1'b0 : !lamp_yellow_q;
          end else begin
            bcnt_q <= bcnt_q - CNT_ONE;
          end
        end
      end else if (!en_q || state_q == ST_BLINK) begin
        state_q       <= ST_RED;
        cnt_q         <= red_load;
        lamp_red_q    <= 1'b1;
        lamp_yellow_q <= 1'b0;
        lamp_green_q  <= 1'b0;
      end else if (tick) begin
        if (cnt_q <= CNT_ONE) begin
          state_q       <= next_d;
          cnt_q         <= next_load;
          lamp_red_q    <= (next_d == ST_RED);
          lamp_yellow_q <= (next_d == ST_YELLOW);
          lamp_green_q  <= (next_d == ST_GREEN);
        end else begin
          cnt_q <= cnt_q - CNT_ONE;
        end
      end
    end
  end

  assign state       = state_q;
  assign lamp_red    = lamp_red_q;
  assign lamp_yellow = lamp_yellow_q;
  assign lamp_green  = lamp_green_q;

endmodule
